// File: rtl/alu_pkg.sv
// Operation codes shared by the ALU controller and the execute stage.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_SUB = 4'b0001,
    OP_ADD = 4'b0010,
    OP_BNE = 4'b0011,
    OP_OR  = 4'b0100,
    OP_XOR = 4'b0101,
    OP_BEQ = 4'b1000
  } alu_op_e;

  localparam int OP_W    = 4;
  localparam int COUNT_W = 16;

endpackage

// File: rtl/alu_exec_stage_if.sv
// Valid/ready request and result channels of the ALU execute stage.
interface alu_exec_stage_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) ();
  import alu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [TAG_W-1:0]  in_tag;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_zero;
  logic              out_taken;
  logic              out_illegal;
  logic [TAG_W-1:0]  out_tag;

  // master: the environment (issue side plus result consumer)
  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_taken, out_illegal, out_tag
  );

  // slave: the execute stage itself
  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_taken, out_illegal, out_tag
  );
endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU: operation, operands -> result, branch taken, illegal flag.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              taken,
  output logic              illegal
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    result  = '0;
    taken   = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_AND: result = a & b;
      OP_SUB: result = a - b;
      OP_ADD: result = a + b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_BEQ: begin
        result = a - b;
        taken  = (a == b);
      end
      OP_BNE: begin
        result = DATA_W'(a != b);
        taken  = (a != b);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Two-stage ALU execute pipeline (A: operands, B: result) with valid/ready
// handshake, flush, and a saturating count of completed results.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  alu_exec_stage_if.slave    bus,
  output logic [COUNT_W-1:0] done_count
);

  logic              a_valid;
  logic [OP_W-1:0]   a_op;
  logic [DATA_W-1:0] a_a;
  logic [DATA_W-1:0] a_b;
  logic [TAG_W-1:0]  a_tag;

  logic              b_valid;
  logic [DATA_W-1:0] b_result;
  logic              b_taken;
  logic              b_illegal;
  logic [TAG_W-1:0]  b_tag;

  logic [DATA_W-1:0] core_result;
  logic              core_taken;
  logic              core_illegal;

  logic b_adv;
  logic a_adv;
  logic in_xfer;
  logic out_xfer;

  alu_core #(.DATA_W(DATA_W)) u_core (
    .op      (a_op),
    .a       (a_a),
    .b       (a_b),
    .result  (core_result),
    .taken   (core_taken),
    .illegal (core_illegal)
  );

  // Each stage may advance when the one downstream is empty or draining.
  assign b_adv    = !b_valid || bus.out_ready;
  assign a_adv    = !a_valid || b_adv;
  assign in_xfer  = bus.in_valid && a_adv;
  assign out_xfer = b_valid && bus.out_ready;

  assign bus.in_ready    = a_adv;
  assign bus.out_valid   = b_valid;
  assign bus.out_result  = b_result;
  assign bus.out_zero    = (b_result == '0);
  assign bus.out_taken   = b_valid && b_taken;
  assign bus.out_illegal = b_valid && b_illegal;
  assign bus.out_tag     = b_tag;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_valid    <= 1'b0;
      b_valid    <= 1'b0;
      done_count <= '0;
    end else begin
      if (out_xfer && (done_count != '1)) done_count <= done_count + 1'b1;
      if (flush) begin
        a_valid <= 1'b0;
        b_valid <= 1'b0;
      end else begin
        if (b_adv) b_valid <= a_valid;
        if (a_adv) a_valid <= bus.in_valid;
      end
    end
  end

  // NOTE: payload registers are qualified by the valid bits, so they carry no reset.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      a_op  <= bus.in_op;
      a_a   <= bus.in_a;
      a_b   <= bus.in_b;
      a_tag <= bus.in_tag;
    end
    if (b_adv && a_valid) begin
      b_result  <= core_result;
      b_taken   <= core_taken;
      b_illegal <= core_illegal;
      b_tag     <= a_tag;
    end
  end

endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 Parameter DATA_W, default 32: operand and result width.
REQ-002 Parameter TAG_W, default 5: destination tag width (rd index).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  upstream offers an operation this cycle.
REQ-006 in_ready  output  1  stage can accept an operation this cycle.
REQ-007 in_op  input  4  Operation code from the ALU controller.
REQ-008 in_a, in_b  input  DATA_W  source operands.
REQ-009 in_tag  input  TAG_W  destination tag, carried unmodified.
REQ-010 flush  input  1  discard all in-flight operations.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out_result  output  DATA_W  computed result.
REQ-014 out_zero  output  1  out_result == 0.
REQ-015 out_taken  output  1  branch condition true.
REQ-016 out_illegal  output  1  in_op was not a defined code.
REQ-017 out_tag  output  TAG_W  tag of the result.
REQ-018 done_count  output  16  count of completed output transfers.

Function
REQ-019 Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
REQ-020 Two registered stages: A (op, operands, tag), B (result, flags, tag); each with a valid bit.
REQ-021 b_adv = !B.valid | out_ready; a_adv = !A.valid | b_adv; in_ready = a_adv (combinational, no dependency on in_valid).
REQ-022 Latency: operation accepted at edge N appears with out_valid=1 after edge N+2 when out_ready held high; throughput one per cycle.
REQ-023 Stall: while out_ready=0 and both stages valid, in_ready=0 and B outputs, A contents held stable.
REQ-024 Codes: 0000 AND; 0001 SUB a-b; 0010 ADD a+b; 0100 OR; 0101 XOR; 1000 BEQ result a-b, taken = (a==b); 0011 BNE result {0..,a!=b}, taken = (a!=b).
REQ-025 taken = 0 for all non-branch codes; add/sub wrap modulo 2^DATA_W, no carry output.
REQ-026 Undefined code: result 0, zero 1, taken 0, illegal 1; transfer still completes normally.
REQ-027 out_zero derived from the registered result, never from inputs.
REQ-028 flush=1: A.valid and B.valid cleared at next edge; a simultaneous input transfer is discarded; a simultaneous output transfer still counts.
REQ-029 done_count increments by 1 per output transfer, saturates at 0xFFFF.
REQ-030 Data registers need not reset; only valid bits and done_count are reset.

Reset
REQ-031 reset_n=0 at an edge: A.valid=0, B.valid=0, done_count=0; reset takes priority over flush and transfers.
REQ-032 During and one cycle after reset: out_valid=0, in_ready=1, out_taken/out_illegal gated to 0 when out_valid=0.
REQ-033 Reset asserted mid-operation drops all in-flight operations without an output transfer.

Structure
REQ-034 Shared package alu_pkg holds the 4-bit Operation code constants (AND, SUB, ADD, BNE, OR, XOR, BEQ) used by both controller and this stage.
REQ-035 Combinational datapath in sub-module alu_core (op, a, b -> result, taken, illegal); alu_exec_stage holds stage registers, handshake and counter.

Verification
REQ-036 Back-to-back: ADD 5+7, SUB 3-5, XOR 0xF0^0xFF with out_ready=1 -> outputs 12, 0xFFFFFFFE, 0x0F on consecutive cycles, 2-cycle latency, tags preserved.
REQ-037 Branch: BEQ a=b=9 -> result 0, zero 1, taken 1; BNE a=1 b=2 -> result 1, taken 1; BNE a=b -> taken 0, zero 1.
REQ-038 Backpressure: out_ready=0 for 4 cycles with 3 ops offered -> exactly 2 accepted, in_ready=0, outputs stable; release -> both drained in order, third accepted.
REQ-039 Flush with both stages full and in_valid=1 -> next cycle out_valid=0, done_count unchanged, no trace of the dropped op.
REQ-040 Illegal code 1111 -> out_illegal 1, result 0, done_count +1; reset mid-stream -> out_valid 0, done_count 0, in_ready 1.
